// File: rtl/serial_parity_receiver_if.sv
// Link bundle for serial_parity_receiver: serial bit input side plus parallel word output side.
interface serial_parity_receiver_if #(
    parameter int WIDTH     = 8,
    parameter int ERR_CNT_W = 8
) ();
    logic                 in_valid;
    logic                 in_bit;
    logic                 out_valid;
    logic [WIDTH-1:0]     out_data;
    logic                 out_parity_err;
    logic [ERR_CNT_W-1:0] err_count;
    logic                 busy;

    modport master (
        output in_valid, in_bit,
        input  out_valid, out_data, out_parity_err, err_count, busy
    );

    modport slave (
        input  in_valid, in_bit,
        output out_valid, out_data, out_parity_err, err_count, busy
    );
endinterface

// File: rtl/serial_parity_receiver.sv
// Deserializes start/data/even-parity frames into WIDTH-bit words and tracks
// a saturating parity-error count.
module serial_parity_receiver #(
    parameter int WIDTH     = 8,
    parameter int ERR_CNT_W = 8
) (
    input logic                    clk,
    input logic                    rst,
    serial_parity_receiver_if.slave link
);
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY
    } state_t;

    state_t           state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic             acc, acc_next;
    logic [WIDTH-1:0] shift, shift_next;
    logic             frame_done;
    logic             frame_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            acc   <= 1'b0;
            shift <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            acc   <= acc_next;
            shift <= shift_next;
        end
    end

    // Every piece of frame state holds unless in_valid is high.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        acc_next   = acc;
        shift_next = shift;
        frame_done = 1'b0;
        frame_err  = 1'b0;
        if (link.in_valid) begin
            case (state)
                IDLE: begin
                    if (link.in_bit) begin
                        state_next = DATA;
                        cnt_next   = '0;
                        acc_next   = 1'b0;
                    end
                end
                DATA: begin
                    shift_next            = shift >> 1;
                    shift_next[WIDTH-1]   = link.in_bit;
                    acc_next              = acc ^ link.in_bit;
                    cnt_next              = cnt + CNT_W'(1);
                    if (cnt == LAST_BIT) begin
                        state_next = PARITY;
                    end
                end
                PARITY: begin
                    frame_done = 1'b1;
                    frame_err  = acc ^ link.in_bit;
                    state_next = IDLE;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            link.out_valid      <= 1'b0;
            link.out_data       <= '0;
            link.out_parity_err <= 1'b0;
            link.err_count      <= '0;
        end else begin
            link.out_valid <= frame_done;
            if (frame_done) begin
                link.out_data       <= shift;
                link.out_parity_err <= frame_err;
                if (frame_err && (link.err_count != '1)) begin
                    link.err_count <= link.err_count + ERR_CNT_W'(1);
                end
            end
        end
    end

    always_comb link.busy = (state != IDLE);
endmodule

// File: tb/tb_serial_parity_receiver.sv
// Scoreboard bench for serial_parity_receiver: one 8-bit counter instance and
// one 2-bit (saturating) counter instance share the same serial stimulus.
module tb_serial_parity_receiver;
    logic clk;
    logic rst;
    int   cyc;

    serial_parity_receiver_if #(.WIDTH(8), .ERR_CNT_W(8)) a ();
    serial_parity_receiver_if #(.WIDTH(8), .ERR_CNT_W(2)) b ();

    serial_parity_receiver #(.WIDTH(8), .ERR_CNT_W(8)) dut_a (
        .clk  (clk),
        .rst  (rst),
        .link (a)
    );

    serial_parity_receiver #(.WIDTH(8), .ERR_CNT_W(2)) dut_b (
        .clk  (clk),
        .rst  (rst),
        .link (b)
    );

    assign b.in_valid = a.in_valid;
    assign b.in_bit   = a.in_bit;

    typedef struct {
        logic [7:0] data;
        logic       err;
        logic [7:0] cnt_a;
        logic [1:0] cnt_b;
        int         cyc;
    } exp_t;

    exp_t       sb[$];
    exp_t       got;
    logic [7:0] cnt_a;
    logic [1:0] cnt_b;
    logic       prev_valid;
    int         total;
    int         passed;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Monitor: pops one expectation per out_valid pulse.
    initial prev_valid = 1'b0;
    always @(negedge clk) begin
        if (!rst) begin
            if (prev_valid) chk("out_valid_not_consecutive", a.out_valid, 0);
            if (a.out_valid || b.out_valid) begin
                if (sb.size() == 0) begin
                    total++;
                    $display("FAIL unexpected_out_valid: got pulse expected none (cycle %0d)", cyc);
                end else begin
                    got = sb.pop_front();
                    chk("a_out_valid", a.out_valid, 1);
                    chk("b_out_valid", b.out_valid, 1);
                    chk("out_valid_cycle", cyc, got.cyc);
                    chk("a_out_data", a.out_data, got.data);
                    chk("b_out_data", b.out_data, got.data);
                    chk("a_out_parity_err", a.out_parity_err, got.err);
                    chk("b_out_parity_err", b.out_parity_err, got.err);
                    chk("a_err_count", a.err_count, got.cnt_a);
                    chk("b_err_count", b.err_count, got.cnt_b);
                    chk("a_busy_at_valid", a.busy, 0);
                end
            end
        end
        prev_valid = a.out_valid;
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_bit(input logic bit_val);
        a.in_valid = 1'b1;
        a.in_bit   = bit_val;
        @(posedge clk);
        #1;
        a.in_valid = 1'b0;
        a.in_bit   = 1'b0;
    endtask

    task automatic stall_busy();
        int n;
        n = $urandom_range(1, 3);
        repeat (n) begin
            @(posedge clk);
            #1;
            chk("busy_during_stall", a.busy, 1);
        end
    endtask

    task automatic check_cleared(input string tag);
        chk({tag, "_out_valid"}, a.out_valid, 0);
        chk({tag, "_out_data"}, a.out_data, 0);
        chk({tag, "_out_parity_err"}, a.out_parity_err, 0);
        chk({tag, "_err_count_a"}, a.err_count, 0);
        chk({tag, "_err_count_b"}, b.err_count, 0);
        chk({tag, "_busy"}, a.busy, 0);
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst   = 1'b0;
        cnt_a = '0;
        cnt_b = '0;
        check_cleared(tag);
    endtask

    // exp_err is the hand-computed parity verdict for (data, parity).
    task automatic send_frame(input logic [7:0] d, input logic p, input logic exp_err, input bit stall);
        logic [7:0] dv;
        dv = d;
        send_bit(1'b1);
        for (int i = 0; i < 8; i++) begin
            if (stall) stall_busy();
            send_bit(dv[i]);
        end
        if (stall) stall_busy();
        if (exp_err) begin
            if (cnt_a != 8'hFF) cnt_a = cnt_a + 8'd1;
            if (cnt_b != 2'd3)  cnt_b = cnt_b + 2'd1;
        end
        sb.push_back('{d, exp_err, cnt_a, cnt_b, cyc + 1});
        send_bit(p);
    endtask

    initial begin
        total      = 0;
        passed     = 0;
        cnt_a      = '0;
        cnt_b      = '0;
        rst        = 1'b1;
        a.in_valid = 1'b0;
        a.in_bit   = 1'b0;
        idle(3);
        rst = 1'b0;
        check_cleared("reset");

        // Good frame then bad frame with the same payload.
        send_frame(8'hA5, 1'b0, 1'b0, 1'b0);
        idle(2);
        chk("busy_after_frame", a.busy, 0);
        chk("out_data_held", a.out_data, 8'hA5);
        send_frame(8'hA5, 1'b1, 1'b1, 1'b0);
        idle(2);
        send_frame(8'h01, 1'b1, 1'b0, 1'b0);
        idle(2);

        // Idle zeros are ignored, then a stalled frame.
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b0);
        chk("busy_idle_zeros", a.busy, 0);
        send_bit(1'b1);
        chk("busy_after_start", a.busy, 1);
        for (int i = 0; i < 8; i++) begin
            stall_busy();
            send_bit(((8'h3C >> i) & 8'h01) != 8'h00);
        end
        stall_busy();
        sb.push_back('{8'h3C, 1'b0, cnt_a, cnt_b, cyc + 1});
        send_bit(1'b0);
        idle(2);
        send_frame(8'h69, 1'b1, 1'b1, 1'b1);
        idle(2);

        // Back-to-back: second start bit lands in the out_valid cycle.
        do_reset("reset_b2b");
        send_frame(8'hFF, 1'b0, 1'b0, 1'b0);
        send_frame(8'h80, 1'b0, 1'b1, 1'b0);
        idle(2);

        // Reset after four data bits discards the partial frame.
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        do_reset("reset_mid_frame");
        idle(12);
        send_frame(8'h5A, 1'b0, 1'b0, 1'b0);
        idle(2);

        // Saturation of the 2-bit counter: 1,2,3,3,3.
        do_reset("reset_sat");
        for (int i = 0; i < 5; i++) begin
            send_frame(8'h00, 1'b1, 1'b1, 1'b0);
            idle(1);
        end
        idle(4);
        chk("scoreboard_drained", sb.size(), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/serial_parity_receiver.md
# serial_parity_receiver

Receiving end of the team's XOR-parity serial link: deserializes a valid-qualified bit stream into WIDTH-bit words and checks even parity with a running XOR accumulator. Sits after the bit-level front end and feeds parallel words plus an error flag to downstream logic. Keeps a saturating count of parity failures for debug readout.

## Interface
- WIDTH, 8, data bits per frame (≥1)
- ERR_CNT_W, 8, width of the parity-error counter (≥1)

- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  in_bit is sampled on this cycle
- in_bit  input  1  serial bit
- out_valid  output  1  one-cycle pulse: frame complete
- out_data  output  WIDTH  received word, held until next frame completes
- out_parity_err  output  1  parity result of last frame, held with out_data
- err_count  output  ERR_CNT_W  saturating count of frames with parity error
- busy  output  1  high while a frame is in progress (state != IDLE)

## Operation
- Frame, one bit per in_valid cycle: start bit (1), WIDTH data bits LSB first, one even-parity bit. Total = WIDTH+2 accepted bits.
- Even parity: frame is good when XOR of data bits and parity bit = 0.
- States:
  - IDLE: in_valid && in_bit==1 → DATA, bit counter cleared, parity accumulator cleared. in_valid && in_bit==0 ignored (idle line).
  - DATA: each in_valid shifts in_bit into shift register (right shift, new bit enters MSB, so first data bit ends at bit 0), acc ^= in_bit, counter++. After WIDTH-th data bit → PARITY.
  - PARITY: on in_valid, err = acc ^ in_bit; load out_data from shift register, out_parity_err = err, pulse out_valid next cycle; → IDLE.
- in_valid low in any state: state, counter, shift register, accumulator hold (stall of any length).
- err_count increments when a frame completes with err=1; saturates at 2^ERR_CNT_W−1, never wraps.
- out_data/out_parity_err change only on frame completion.

## Timing
- Reset: state IDLE, out_valid=0, out_data=0, out_parity_err=0, err_count=0, busy=0, counter/accumulator/shift register 0.
- Reset mid-frame: partial frame discarded, no out_valid, err_count unchanged by it (cleared by reset).
- Latency: out_valid, out_data, out_parity_err, updated err_count all visible the cycle after the parity bit is sampled.
- busy rises the cycle after the start bit is sampled; falls the cycle after the parity bit is sampled (same cycle out_valid is high).
- Back-to-back: start bit of the next frame may be sampled in the cycle out_valid is high; accepted normally.
- out_valid is never asserted two consecutive cycles; minimum spacing WIDTH+2 cycles.

## Test plan
- Good frame: WIDTH=8, bits 1, A5 LSB first (1,0,1,0,0,1,0,1), parity 0, in_valid every cycle → out_valid on cycle 11 only, out_data=8'hA5, out_parity_err=0, err_count=0.
- Bad frame: same with parity 1 → out_data=8'hA5, out_parity_err=1, err_count=1; then good frame 8'h01 parity 1 → err=0, err_count stays 1.
- Stalls: frame 8'h3C parity 0 with in_valid deasserted 1–3 random cycles between bits → out_data=8'h3C, err=0; busy high throughout; idle 0 bits before start ignored.
- Back-to-back: frames 8'hFF/p0 and 8'h80/p0 with no gap (second start bit in out_valid cycle) → two out_valid pulses 10 cycles apart, data FF then 80, err 0 then 1, err_count=1.
- Reset mid-frame: assert rst after 4 data bits → all outputs 0 next cycle, no out_valid; following good frame 8'h5A/p0 received correctly.
- Saturation: ERR_CNT_W=2, five bad frames → err_count 1,2,3,3,3.
